// File: rtl/blur_pkg.sv
// Shared types and default geometry for the blur pipeline front end.
package blur_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} win_state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_IMG_W  = 32;
  localparam int DEF_IMG_H  = 32;

endpackage

// File: rtl/blur_window_ctrl.sv
// Frame sequencer ahead of the 3x3 window generator: tracks raster position,
// flags complete interior windows and stalls the stream until each is consumed.
module blur_window_ctrl
  import blur_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  localparam int ROW_W  = $clog2(IMG_H),
  localparam int COL_W  = $clog2(IMG_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  output logic              win_shift,
  output logic [DATA_W-1:0] win_pixel,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ROW_W-1:0]  ctr_row,
  output logic [COL_W-1:0]  ctr_col,
  output logic              frame_done,
  output logic              sof_err
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);

  win_state_e       state;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             acc;
  logic [ROW_W-1:0] pos_row;
  logic [COL_W-1:0] pos_col;
  logic             pos_last;
  logic             pos_interior;

  assign s_ready   = (state != DONE) && (!m_valid || m_ready);
  assign acc       = s_valid && s_ready;
  assign win_shift = acc && ((state != IDLE) || s_sof);
  assign win_pixel = s_data;

  // A start-of-frame marker always re-anchors the accepted pixel at (0,0).
  assign pos_row      = s_sof ? '0 : row;
  assign pos_col      = s_sof ? '0 : col;
  assign pos_last     = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
  assign pos_interior = (pos_row >= ROW_TWO) && (pos_col >= COL_TWO);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      m_valid    <= 1'b0;
      ctr_row    <= '0;
      ctr_col    <= '0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
      if (m_ready) m_valid <= 1'b0;

      case (state)
        // In IDLE win_shift implies s_sof, so both states share the advance path.
        IDLE, RUN: begin
          if (win_shift) begin
            if (state == RUN && s_sof) sof_err <= 1'b1;
            if (pos_interior) begin
              m_valid <= 1'b1;
              ctr_row <= pos_row - ROW_W'(1);
              ctr_col <= pos_col - COL_W'(1);
            end
            if (pos_last) begin
              state <= DONE;
              row   <= '0;
              col   <= '0;
            end else begin
              state <= RUN;
              if (pos_col == COL_LAST) begin
                col <= '0;
                row <= pos_row + ROW_W'(1);
              end else begin
                col <= pos_col + COL_W'(1);
                row <= pos_row;
              end
            end
          end
        end
        DONE: begin
          if (!m_valid || m_ready) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blur_window_ctrl.sv
// Directed bench for blur_window_ctrl on a 4x4 image with pixel value 4*r+c;
// rebuilds the 3x3 taps from the win_shift/win_pixel stream.
module tb_blur_window_ctrl;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n, s_valid, s_ready, s_sof, win_shift;
  logic       m_valid, m_ready, frame_done, sof_err;
  logic [7:0] s_data, win_pixel;
  logic [1:0] ctr_row, ctr_col;

  int total = 0, bad = 0, cycle = 0;
  int histq[$];
  int winRow[$], winCol[$];
  logic [71:0] winTaps[$];
  int doneCount = 0, doneCycle = 0, sofErrCount = 0, lastAccCycle = 0;
  int stallCycles = 0, waitCycles = 0, histLen = 0;
  bit readyNow, shiftNow;

  blur_window_ctrl #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sof(s_sof), .win_shift(win_shift), .win_pixel(win_pixel),
    .m_valid(m_valid), .m_ready(m_ready), .ctr_row(ctr_row), .ctr_col(ctr_col),
    .frame_done(frame_done), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] tapsNow();
    logic [71:0] v = '0;
    int n = histq.size();
    if (n >= 2 * W + 3)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          v = {v[63:0], 8'(histq[n - 1 - (2 - i) * W - (2 - j)])};
    return v;
  endfunction

  function automatic logic [71:0] expTaps(input int r, input int c);
    logic [71:0] v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v = {v[63:0], 8'(W * (r - 1 + i) + (c - 1 + j))};
    return v;
  endfunction

  // One clock: drive m_ready, sample everything mid-low-phase, then advance.
  task automatic stepCycle();
    m_ready = !(m_valid && stallCycles > 0);
    #1;
    readyNow = s_ready;
    shiftNow = win_shift;
    if (m_valid && !m_ready) begin
      checkOutput("stall_ready", 72'(s_ready), 72'(0));
      checkOutput("stall_shift", 72'(win_shift), 72'(0));
      stallCycles--;
    end
    if (m_valid && m_ready) begin
      winRow.push_back(int'(ctr_row));
      winCol.push_back(int'(ctr_col));
      winTaps.push_back(tapsNow());
    end
    if (frame_done) begin
      doneCount++;
      doneCycle = cycle;
    end
    if (sof_err) sofErrCount++;
    if (shiftNow) histq.push_back(int'(win_pixel));
    if (s_valid && s_ready) lastAccCycle = cycle;
    @(posedge clk);
    @(negedge clk);
    cycle++;
  endtask

  task automatic applyStimulus(input int value, input bit sof);
    bit accepted = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'(value);
    s_sof   = sof;
    waitCycles = 0;
    for (int k = 0; k < 20 && !accepted; k++) begin
      stepCycle();
      if (readyNow) accepted = 1'b1;
      else waitCycles++;
    end
    if (!accepted) checkOutput("accept_timeout", 72'(0), 72'(1));
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    repeat (n) stepCycle();
  endtask

  task automatic sendPixels(input int start, input int count, input bit sofFirst);
    for (int idx = start; idx < start + count; idx++)
      applyStimulus(idx, sofFirst && idx == 0);
  endtask

  task automatic clearLog();
    winRow.delete();
    winCol.delete();
    winTaps.delete();
    doneCount = 0;
    sofErrCount = 0;
  endtask

  // Windows repeat per frame in order (1,1),(1,2),(2,1),(2,2).
  task automatic checkWindows(input string tag, input int n);
    checkOutput({tag, "_count"}, 72'(winRow.size()), 72'(n));
    for (int i = 0; i < winRow.size(); i++) begin
      int r = 1 + (i % 4) / 2;
      int c = 1 + (i % 4) % 2;
      checkOutput({tag, "_center"}, 72'({winRow[i][7:0], winCol[i][7:0]}),
                  72'({8'(r), 8'(c)}));
      checkOutput({tag, "_taps"}, winTaps[i], expTaps(r, c));
    end
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; m_ready = 1'b1;
    @(negedge clk);
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    #1;
    checkOutput("rst_m_valid", 72'(m_valid), 72'(0));
    checkOutput("rst_ctr", 72'({ctr_row, ctr_col}), 72'(0));
    checkOutput("rst_frame_done", 72'(frame_done), 72'(0));
    checkOutput("rst_sof_err", 72'(sof_err), 72'(0));
    checkOutput("rst_s_ready", 72'(s_ready), 72'(1));
    @(negedge clk);

    // Plain frame
    clearLog();
    sendPixels(0, 16, 1'b1);
    idleCycles(4);
    checkWindows("basic", 4);
    checkOutput("basic_done", 72'(doneCount), 72'(1));
    checkOutput("basic_done_lat", 72'(doneCycle - lastAccCycle), 72'(2));
    checkOutput("basic_sof_err", 72'(sofErrCount), 72'(0));

    // Three-cycle hold on the first window
    clearLog();
    stallCycles = 3;
    sendPixels(0, 16, 1'b1);
    idleCycles(4);
    checkWindows("stall", 4);
    checkOutput("stall_used", 72'(stallCycles), 72'(0));
    checkOutput("stall_done", 72'(doneCount), 72'(1));

    // Unmarked pixels in IDLE are dropped
    clearLog();
    histLen = histq.size();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(20 + k, 1'b0);
      checkOutput("drop_shift", 72'(shiftNow), 72'(0));
    end
    checkOutput("drop_hist", 72'(histq.size()), 72'(histLen));
    sendPixels(0, 16, 1'b1);
    idleCycles(4);
    checkWindows("drop", 4);
    checkOutput("drop_done", 72'(doneCount), 72'(1));

    // s_sof reasserted at pixel (2,1)
    clearLog();
    sendPixels(0, 9, 1'b1);
    sendPixels(0, 10, 1'b1);
    checkOutput("resof_early_win", 72'(winRow.size()), 72'(0));
    checkOutput("resof_err", 72'(sofErrCount), 72'(1));
    sendPixels(10, 6, 1'b0);
    idleCycles(4);
    checkWindows("resof", 4);
    checkOutput("resof_err_once", 72'(sofErrCount), 72'(1));
    checkOutput("resof_done", 72'(doneCount), 72'(1));

    // Reset mid-RUN while a window is flagged
    sendPixels(0, 11, 1'b1);
    #1;
    checkOutput("midrst_pre_valid", 72'(m_valid), 72'(1));
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    #1;
    checkOutput("midrst_valid", 72'(m_valid), 72'(0));
    checkOutput("midrst_ctr", 72'({ctr_row, ctr_col}), 72'(0));
    applyStimulus(7, 1'b0);
    checkOutput("midrst_idle_drop", 72'(shiftNow), 72'(0));
    clearLog();
    sendPixels(0, 16, 1'b1);
    idleCycles(4);
    checkWindows("midrst", 4);
    checkOutput("midrst_done", 72'(doneCount), 72'(1));

    // Back-to-back frames with s_valid held high
    clearLog();
    sendPixels(0, 16, 1'b1);
    applyStimulus(0, 1'b1);
    checkOutput("b2b_waited", 72'(waitCycles > 0), 72'(1));
    checkOutput("b2b_done_first", 72'(doneCount), 72'(1));
    checkOutput("b2b_sof_shift", 72'(shiftNow), 72'(1));
    sendPixels(1, 15, 1'b0);
    idleCycles(4);
    checkWindows("b2b", 8);
    checkOutput("b2b_done", 72'(doneCount), 72'(2));
    checkOutput("b2b_sof_err", 72'(sofErrCount), 72'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
